// File: rtl/chunked_adder_pkg.sv
// Shared definitions for the chunk-serial adder: FSM encoding and sizing helpers.
package chunked_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk counter never narrower than one bit, even for a single-chunk build.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple adder; also exposes the carry into the top bit for overflow.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co       = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle add/sub: one CHUNK-bit slice per cycle, carry held in a register
// between slices, valid/ready on both sides.
module chunked_serial_adder
  import chunked_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("chunked_serial_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state, state_nxt;
  logic             rdy_q;
  logic [WIDTH-1:0] opa, opb, acc, acc_nxt;
  logic             carry, cout_q, ovf_q;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] cs;
  logic             cco, cmsb;
  logic             last, accept;

  // rdy_q keeps in_ready low while reset is held and until the first edge after it.
  assign in_ready  = rdy_q && (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == LAST);

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .x        (opa[CHUNK-1:0]),
    .y        (opb[CHUNK-1:0]),
    .ci       (carry),
    .s        (cs),
    .co       (cco),
    .c_msb_in (cmsb)
  );

  // Result slices enter at the MSB end so the final slice lands in place.
  if (CHUNK == WIDTH) begin : g_full
    assign acc_nxt = cs;
  end else begin : g_shift
    assign acc_nxt = {cs, acc[WIDTH-1:CHUNK]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Subtract folds into the add as a + ~b + ~cin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q  <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (accept) begin
        opa   <= a;
        opb   <= b ^ {WIDTH{sub}};
        carry <= cin ^ sub;
        cnt   <= '0;
      end else if (state == RUN) begin
        opa   <= opa >> CHUNK;
        opb   <= opb >> CHUNK;
        acc   <= acc_nxt;
        carry <= cco;
        cnt   <= cnt + 1'b1;
        if (last) begin
          cout_q <= cco;
          ovf_q  <= cco ^ cmsb;
        end
      end
    end
  end

  assign sum  = acc;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Scoreboard bench: default 32/8 instance for directed cases plus three extra
// geometries (32/32, 32/1, 12/4) exercised with random add/sub traffic.
module tb_chunked_serial_adder;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [31:0] a = '0, b = '0, sum;
  logic        cin = 1'b0, sub = 1'b0, cout, ovf;

  logic        xin_valid [3], xin_ready [3], xout_valid [3], xout_ready [3];
  logic        xcin [3], xsub [3], xcout [3], xovf [3];
  logic [31:0] xa [3], xb [3], xsum [3];

  exp_t sbq[$];
  exp_t xq[$];
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  chunked_serial_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int W = (g == 2) ? 12 : 32;
    localparam int C = (g == 0) ? 32 : (g == 1) ? 1 : 4;
    logic [W-1:0] s_w;
    chunked_serial_adder #(.WIDTH(W), .CHUNK(C)) u_x (
      .clk(clk), .rst(rst), .in_valid(xin_valid[g]), .in_ready(xin_ready[g]),
      .a(xa[g][W-1:0]), .b(xb[g][W-1:0]), .cin(xcin[g]), .sub(xsub[g]),
      .out_valid(xout_valid[g]), .out_ready(xout_ready[g]), .sum(s_w),
      .cout(xcout[g]), .ovf(xovf[g])
    );
    assign xsum[g] = 32'(s_w);
  end

  function automatic exp_t mk(input logic [31:0] s, input logic c, input logic o);
    exp_t r;
    r.s = s; r.c = c; r.o = o;
    return r;
  endfunction

  // Reference: plain wide addition, overflow from operand/result signs.
  function automatic exp_t model(input int w, input logic [31:0] x, input logic [31:0] y,
                                 input logic ci, input logic sb);
    logic [31:0] m, xx, yy;
    logic [32:0] full;
    exp_t r;
    m    = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_0FFF;
    xx   = x & m;
    yy   = (sb ? ~y : y) & m;
    full = {1'b0, xx} + {1'b0, yy} + 33'(ci ^ sb);
    r.s  = full[31:0] & m;
    r.c  = full[w];
    r.o  = (xx[w-1] == yy[w-1]) && (r.s[w-1] != xx[w-1]);
    return r;
  endfunction

  task automatic drive_op(input logic [31:0] ta, input logic [31:0] tb2,
                          input logic tc, input logic ts, input exp_t e);
    int cyc = 0;
    while (!in_ready && cyc < 200) begin @(posedge clk); #1; cyc++; end
    if (!in_ready) begin
      nchk++; nerr++;
      $display("FAIL issue_timeout in_ready=%0b required 1", in_ready);
    end
    a = ta; b = tb2; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sbq.push_back(e);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    nchk++;
    if ({in_ready, out_valid, sum, cout, ovf} !== 36'h0) begin
      nerr++;
      $display("FAIL reset_state got rdy=%0b ov=%0b sum=%h c=%0b o=%0b required all 0",
               in_ready, out_valid, sum, cout, ovf);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    nchk++;
    if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL reset_release in_ready=%0b required 1", in_ready);
    end
  endtask

  task automatic test_carry();
    int   lat;
    exp_t e;
    out_ready = 1'b1;
    drive_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, mk(32'h0, 1'b1, 1'b0));
    wait_out(lat);
    nchk++;
    if (lat !== 4) begin nerr++; $display("FAIL carry_latency got %0d required 4", lat); end
    e = sbq.pop_front();
    nchk++;
    if ({sum, cout, ovf} !== e) begin
      nerr++; $display("FAIL carry_result got %h/%0b/%0b required %h/%0b/%0b", sum, cout, ovf, e.s, e.c, e.o);
    end
    @(posedge clk); #1;
    nchk++;
    if ({in_ready, out_valid} !== 2'b10) begin
      nerr++; $display("FAIL carry_handoff rdy/ov=%b required 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_overflow_sub();
    logic [31:0] ta [4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h5, 32'h5};
    logic [31:0] tb2 [4] = '{32'h1, 32'h1, 32'h7, 32'h7};
    logic        tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic        ts [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    exp_t        te [4];
    int          lat;
    exp_t        e;
    te[0] = mk(32'h8000_0000, 1'b0, 1'b1);
    te[1] = mk(32'h7FFF_FFFF, 1'b1, 1'b1);
    te[2] = mk(32'hFFFF_FFFE, 1'b0, 1'b0);
    te[3] = mk(32'hFFFF_FFFD, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive_op(ta[i], tb2[i], tc[i], ts[i], te[i]);
      wait_out(lat);
      nchk++;
      if (lat !== 4) begin nerr++; $display("FAIL ovf_sub_latency[%0d] got %0d required 4", i, lat); end
      e = sbq.pop_front();
      nchk++;
      if ({sum, cout, ovf} !== e) begin
        nerr++;
        $display("FAIL ovf_sub_result[%0d] got %h/%0b/%0b required %h/%0b/%0b", i, sum, cout, ovf, e.s, e.c, e.o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    exp_t e;
    out_ready = 1'b0;
    drive_op(32'h0F0F_0F0F, 32'h1010_1010, 1'b1, 1'b0, mk(32'h1F1F_1F20, 1'b0, 1'b0));
    wait_out(lat);
    nchk++;
    if (lat !== 4) begin nerr++; $display("FAIL bp_latency got %0d required 4", lat); end
    e = sbq[0];
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin a = 32'hDEAD_BEEF; b = 32'h1234_5678; sub = 1'b1; in_valid = 1'b1; end
      if (i == 4) in_valid = 1'b0;
      nchk++;
      if ({out_valid, in_ready, sum, cout, ovf} !== {2'b10, e}) begin
        nerr++;
        $display("FAIL bp_hold[%0d] got ov=%0b rdy=%0b %h/%0b/%0b required ov=1 rdy=0 %h/%0b/%0b",
                 i, out_valid, in_ready, sum, cout, ovf, e.s, e.c, e.o);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    void'(sbq.pop_front());
    nchk++;
    if ({in_ready, out_valid} !== 2'b10) begin
      nerr++; $display("FAIL bp_release rdy/ov=%b required 10", {in_ready, out_valid});
    end
    repeat (5) @(posedge clk);
    #1;
    nchk++;
    if ({in_ready, out_valid} !== 2'b10) begin
      nerr++; $display("FAIL bp_ignored_in rdy/ov=%b required 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_reset_mid();
    int   lat;
    exp_t e;
    drive_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, mk(32'h2345_6789, 1'b0, 1'b0));
    void'(sbq.pop_front());
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    nchk++;
    if ({in_ready, out_valid, sum, cout, ovf} !== 36'h0) begin
      nerr++;
      $display("FAIL midreset_clear got rdy=%0b ov=%0b sum=%h c=%0b o=%0b required all 0",
               in_ready, out_valid, sum, cout, ovf);
    end
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    nchk++;
    if ({in_ready, out_valid} !== 2'b10) begin
      nerr++; $display("FAIL midreset_idle rdy/ov=%b required 10", {in_ready, out_valid});
    end
    drive_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, mk(32'h2345_6789, 1'b0, 1'b0));
    wait_out(lat);
    nchk++;
    if (lat !== 4) begin nerr++; $display("FAIL midreset_latency got %0d required 4", lat); end
    e = sbq.pop_front();
    nchk++;
    if ({sum, cout, ovf} !== e) begin
      nerr++; $display("FAIL midreset_result got %h/%0b/%0b required %h/%0b/%0b", sum, cout, ovf, e.s, e.c, e.o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random(input int g, input int w, input int explat);
    int          lat, cyc;
    exp_t        e;
    logic [31:0] m, ra, rb;
    logic        rc, rs;
    m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_0FFF;
    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
      if (i == 0) begin ra = '1; rb = 32'h1; rc = 1'b0; rs = 1'b0; end
      if (i == 1) begin ra = '0; rb = '0; rc = 1'b0; rs = 1'b1; end
      ra = ra & m; rb = rb & m;
      cyc = 0;
      while (!xin_ready[g] && cyc < 200) begin @(posedge clk); #1; cyc++; end
      xa[g] = ra; xb[g] = rb; xcin[g] = rc; xsub[g] = rs; xin_valid[g] = 1'b1;
      @(posedge clk); #1;
      xin_valid[g] = 1'b0;
      xq.push_back(model(w, ra, rb, rc, rs));
      lat = 0;
      while (!xout_valid[g] && lat < 200) begin @(posedge clk); #1; lat++; end
      nchk++;
      if (lat !== explat) begin
        nerr++; $display("FAIL rand_latency cfg%0d[%0d] got %0d required %0d", g, i, lat, explat);
      end
      e = xq.pop_front();
      nchk++;
      if ({xsum[g], xcout[g], xovf[g]} !== e) begin
        nerr++;
        $display("FAIL rand_result cfg%0d[%0d] a=%h b=%h ci=%0b sub=%0b got %h/%0b/%0b required %h/%0b/%0b",
                 g, i, ra, rb, rc, rs, xsum[g], xcout[g], xovf[g], e.s, e.c, e.o);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      xin_valid[g] = 1'b0; xout_ready[g] = 1'b1; xa[g] = '0; xb[g] = '0;
      xcin[g] = 1'b0; xsub[g] = 1'b0;
    end
    test_reset();
    test_carry();
    test_overflow_sub();
    test_backpressure();
    test_reset_mid();
    test_random(0, 32, 1);
    test_random(1, 32, 32);
    test_random(2, 12, 3);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
